// File: rtl/sipo_ctrl_pkg.sv
// ============================================================================
// Module : sipo_ctrl_pkg
// Brief  : Shared types and helpers for the SIPO framing controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sipo_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sipo_shift_unit.sv
// ============================================================================
// Module : sipo_shift_unit
// Brief  : Serial-in shift register; q exposes the contents including the bit
//          being shifted this cycle so a completing word can be captured at once.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sipo_shift_unit #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    base = clr ? '0 : sreg_q;
  end

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {base[WIDTH-2:0], sin};
    end else begin : g_lsb_first
      assign shifted = {sin, base[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    sreg_d = shift_en ? shifted : base;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign q = shifted;

endmodule

`default_nettype wire

// File: rtl/sipo_frame_ctrl.sv
// ============================================================================
// Module : sipo_frame_ctrl
// Brief  : Frames a qualified serial stream into WIDTH-bit words and hands
//          them out through a one-entry valid/ready output register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sin,
  input  logic                         sin_valid,
  input  logic                         frame_start,
  input  logic                         out_ready,
  input  logic                         clear_err,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  output logic                         busy,
  output logic [cnt_width(WIDTH)-1:0]  bit_cnt,
  output logic                         overrun,
  output logic                         abort_err
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
  logic             abort_q, abort_d;

  logic             abort;
  logic             complete;
  logic [WIDTH-1:0] word;

  sipo_shift_unit #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .shift_en (sin_valid),
    .clr      (abort),
    .sin      (sin),
    .q        (word)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    abort    = 1'b0;
    complete = 1'b0;

    case (state_q)
      IDLE: begin
        // Bits without a frame marker are simply dropped here.
        if (sin_valid && frame_start) begin
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sin_valid) begin
          if (frame_start) begin
            abort = 1'b1;
            cnt_d = CW'(1);
          end else if (cnt_q == CW'(WIDTH - 1)) begin
            complete = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    overrun_d   = clear_err ? 1'b0 : overrun_q;
    abort_d     = clear_err ? 1'b0 : abort_q;

    if (complete) begin
      // Slot is free if empty or being drained this same cycle.
      if (!out_valid_q || out_ready) begin
        out_data_d  = word;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (abort) begin
      abort_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      abort_q     <= abort_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == SHIFT);
  assign bit_cnt   = cnt_q;
  assign overrun   = overrun_q;
  assign abort_err = abort_q;

endmodule

`default_nettype wire

// File: tb/tb_sipo_frame_ctrl.sv
// ============================================================================
// Module : tb_sipo_frame_ctrl
// Brief  : Directed self-checking bench; one MSB-first and one LSB-first DUT.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sipo_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset, sin, sin_valid, frame_start, out_ready, clear_err;
  logic [7:0] out_data, out_data_l;
  logic       out_valid, busy, overrun, abort_err;
  logic       out_valid_l, busy_l, overrun_l, abort_err_l;
  logic [3:0] bit_cnt, bit_cnt_l;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sipo_frame_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid),
    .frame_start(frame_start), .out_ready(out_ready), .clear_err(clear_err),
    .out_data(out_data), .out_valid(out_valid), .busy(busy),
    .bit_cnt(bit_cnt), .overrun(overrun), .abort_err(abort_err)
  );

  sipo_frame_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid),
    .frame_start(frame_start), .out_ready(out_ready), .clear_err(clear_err),
    .out_data(out_data_l), .out_valid(out_valid_l), .busy(busy_l),
    .bit_cnt(bit_cnt_l), .overrun(overrun_l), .abort_err(abort_err_l)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one valid bit; inputs are changed 1 time unit after a rising edge.
  task automatic send_bit(input logic b, input logic fs);
    sin         = b;
    sin_valid   = 1'b1;
    frame_start = fs;
    tick();
    sin_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  // Contiguous word, first bit sent is w[7].
  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      sin         = w[i];
      sin_valid   = 1'b1;
      frame_start = (i == 7);
      tick();
    end
    sin_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    int         gap;

    reset = 1'b1; sin = 1'b0; sin_valid = 1'b0; frame_start = 1'b0;
    out_ready = 1'b0; clear_err = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_bit_cnt",   64'(bit_cnt),   64'd0);
    chk("rst_overrun",   64'(overrun),   64'd0);
    chk("rst_abort",     64'(abort_err), 64'd0);

    // Stray bit without frame_start is discarded.
    send_bit(1'b1, 1'b0);
    chk("idle_discard_busy", 64'(busy), 64'd0);

    // 1,0,1,0,... -> AA (MSB first) / 55 (LSB first)
    out_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    chk("t1_busy1",    64'(busy),    64'd1);
    chk("t1_bitcnt1",  64'(bit_cnt), 64'd1);
    for (int i = 1; i < 7; i++) send_bit(logic'(i % 2 == 0), 1'b0);
    chk("t1_no_valid_yet", 64'(out_valid), 64'd0);
    send_bit(1'b0, 1'b0);
    chk("t1_valid",      64'(out_valid),  64'd1);
    chk("t1_data_msb",   64'(out_data),   64'hAA);
    chk("t1_data_lsb",   64'(out_data_l), 64'h55);
    chk("t1_bitcnt0",    64'(bit_cnt),    64'd0);
    chk("t1_idle",       64'(busy),       64'd0);
    tick();
    chk("t1_drained",    64'(out_valid),  64'd0);

    // Back-to-back A5 then 3C with no consumer.
    out_ready = 1'b0;
    send_word(8'hA5);
    chk("t2_valid_a5",   64'(out_valid), 64'd1);
    chk("t2_data_a5",    64'(out_data),  64'hA5);
    chk("t2_no_ovr_yet", 64'(overrun),   64'd0);
    send_word(8'h3C);
    chk("t2_overrun",    64'(overrun),   64'd1);
    chk("t2_data_held",  64'(out_data),  64'hA5);
    chk("t2_valid_held", 64'(out_valid), 64'd1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("t2_ovr_clr",    64'(overrun),   64'd0);

    // 0F completes in the cycle that A5 is accepted.
    w = 8'h0F;
    for (int i = 7; i >= 0; i--) begin
      out_ready = (i == 0);
      send_bit(w[i], i == 7);
    end
    chk("t3_valid",   64'(out_valid), 64'd1);
    chk("t3_data",    64'(out_data),  64'h0F);
    chk("t3_no_ovr",  64'(overrun),   64'd0);
    out_ready = 1'b1;
    tick();
    chk("t3_drained", 64'(out_valid), 64'd0);

    // Abort on 5th bit; the restarted word is 1001_1001.
    for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
    chk("t4_bitcnt4", 64'(bit_cnt), 64'd4);
    send_bit(1'b1, 1'b1);
    chk("t4_abort",   64'(abort_err), 64'd1);
    chk("t4_bitcnt1", 64'(bit_cnt),   64'd1);
    chk("t4_busy",    64'(busy),      64'd1);
    w = 8'h99;
    for (int i = 6; i >= 0; i--) send_bit(w[i], 1'b0);
    chk("t4_valid",    64'(out_valid),  64'd1);
    chk("t4_data",     64'(out_data),   64'h99);
    chk("t4_data_lsb", 64'(out_data_l), 64'h99);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("t4_abort_clr", 64'(abort_err), 64'd0);
    chk("t4_drained",   64'(out_valid), 64'd0);

    // C3 with random idle gaps between bits.
    w = 8'hC3;
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i], i == 7);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        sin = ~sin;
        tick();
      end
      if (i != 0) chk("t5_bitcnt", 64'(bit_cnt), 64'(8 - i));
    end
    chk("t5_data", 64'(out_data), 64'hC3);
    tick();

    // Reset mid-word with a pending word and an abort presented.
    out_ready = 1'b0;
    send_word(8'h81);
    for (int i = 0; i < 4; i++) send_bit(1'b0, i == 0);
    chk("t6_bitcnt4",  64'(bit_cnt),   64'd4);
    chk("t6_pending",  64'(out_valid), 64'd1);
    reset = 1'b1; sin_valid = 1'b1; frame_start = 1'b1;
    tick();
    reset = 1'b0; sin_valid = 1'b0; frame_start = 1'b0;
    chk("t6_valid",   64'(out_valid), 64'd0);
    chk("t6_data",    64'(out_data),  64'd0);
    chk("t6_busy",    64'(busy),      64'd0);
    chk("t6_bitcnt",  64'(bit_cnt),   64'd0);
    chk("t6_overrun", 64'(overrun),   64'd0);
    chk("t6_abort",   64'(abort_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sipo_frame_ctrl.md
# sipo_frame_ctrl

Framing controller that sequences a serial-in/parallel-out shift register. It qualifies incoming serial bits, counts them into WIDTH-bit words, and transfers each completed word to a one-entry output register. The output register uses a valid/ready handshake. The block sits between a bit-serial source and any parallel consumer, and replaces free-running SIPO capture plus manual load pulses.

## Interface
- WIDTH, 8: bits per word; legal range 2 to 64.
- MSB_FIRST, 1: 1 places the first received bit in out_data[WIDTH-1]; 0 places it in out_data[0].

- clk  in  1  sole clock; all logic samples on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sin  in  1  serial data bit.
- sin_valid  in  1  sin is sampled only in cycles where this is high.
- frame_start  in  1  marks the current valid bit as bit 0 of a new word; ignored when sin_valid=0.
- out_ready  in  1  consumer accepts out_data this cycle.
- clear_err  in  1  clears the sticky error flags.
- out_data  out  WIDTH  completed word.
- out_valid  out  1  out_data holds an unconsumed word.
- busy  out  1  a word is partially assembled.
- bit_cnt  out  $clog2(WIDTH+1)  number of bits assembled in the current word.
- overrun  out  1  sticky: a completed word was dropped.
- abort_err  out  1  sticky: frame_start arrived mid-word.

## Operation
- FSM states: IDLE, SHIFT.
- IDLE
  - sin_valid=1 and frame_start=1: shift sin in, set bit_cnt=1, go to SHIFT.
  - sin_valid=1 with frame_start=0: discard the bit and stay in IDLE.
- SHIFT
  - Each sin_valid=1 cycle shifts sin in and increments bit_cnt.
  - On the WIDTH-th bit, the word completes: bit_cnt returns to 0 and the FSM returns to IDLE.
- Back-to-back frames: when the word completes and frame_start=1 is already asserted on the next valid bit, the FSM re-enters SHIFT with no gap.
- frame_start with sin_valid in SHIFT:
  - The partial word is discarded and abort_err is set.
  - The current bit becomes bit 0 and bit_cnt=1.
  - If this bit would have completed the word, frame_start wins: no word is emitted and abort_err is set.
- Word completion with an empty output register, or with out_valid=1 and out_ready=1 in the same cycle: the word is loaded into out_data and out_valid=1.
- Word completion with out_valid=1 and out_ready=0: the new word is dropped, overrun is set, and out_data is unchanged.
- Handshake:
  - A transfer occurs when out_valid and out_ready are both high.
  - out_valid deasserts after a transfer unless a new word loads in the same cycle.
  - out_data is stable while out_valid=1 and out_ready=0.
- clear_err=1 clears overrun and abort_err. If a new error event occurs in the same cycle, the set wins.
- busy = (state == SHIFT).

## Timing
- Reset values: out_data=0, out_valid=0, busy=0, bit_cnt=0, overrun=0, abort_err=0, FSM=IDLE, shift register=0.
- reset asserted mid-word or with a pending word discards both, with no error flags raised.
- Latency: the word is visible with out_valid=1 in the cycle after the edge that samples its last bit.
- Minimum word time is WIDTH cycles with sin_valid held high. Sustained throughput is 1 word per WIDTH cycles with no bubbles, provided out_ready is high at each completion.
- sin_valid=0 cycles in SHIFT stall assembly indefinitely; there is no timeout.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package sipo_ctrl_pkg:
  - state typedef (IDLE, SHIFT).
  - function computing the bit_cnt width.
- Sub-module sipo_shift_unit #(WIDTH, MSB_FIRST): shift register with shift_en, clr and parallel q.
  - The controller drives shift_en = sin_valid.
  - The controller drives clr on abort.
- The controller holds the FSM, bit counter, output register and error flags.

## Test plan
- Reset, then frame_start+sin_valid with bits 1,0,1,0,1,0,1,0, out_ready=1 -> out_valid one cycle after the last bit, out_data=8'hAA (MSB_FIRST=1); 8'h55 with MSB_FIRST=0.
- Two back-to-back frames 8'hA5 then 8'h3C with sin_valid held high and out_ready held low -> first word held, second dropped, overrun=1, out_data stays 8'hA5; clear_err clears overrun.
- Word completes in the same cycle out_ready accepts the previous word -> new word loads, out_valid stays 1, no overrun.
- frame_start on the 5th bit of a word -> abort_err=1, bit_cnt=1, the following 7 bits complete a fresh word with the correct value.
- sin_valid gaps of random length (0-3 cycles) between bits of 8'hC3 -> out_data=8'hC3, bit_cnt tracks only valid bits.
- reset asserted at bit_cnt=4 with a pending word -> all outputs return to reset values the next cycle, error flags stay 0.
